// File: rtl/powerup_slot_ctrl_pkg.sv
// Shared definitions for the powerup slot controller.
//   slot_state_t   : lifecycle state encoding (ARMED / HELD / RESPAWN)
//   OFFSCREEN      : coordinate reported while the powerup is off the map
//   DEF_SPRITE_*   : default sprite box size used by the overlap test
//   MMIO_*_ADDR    : MMIO word addresses the processor wrapper decodes
//   abs_diff33     : |a - b| computed at 33 bits so it never wraps
package powerup_slot_ctrl_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    HELD    = 2'd1,
    RESPAWN = 2'd2
  } slot_state_t;

  localparam logic [31:0] OFFSCREEN = 32'hFFFF_FFFF;

  localparam int DEF_SPRITE_W = 32;
  localparam int DEF_SPRITE_H = 32;

  localparam int MMIO_PU_BASE_ADDR = 4202;
  localparam int MMIO_PU_LAST_ADDR = 4205;

  // Both operands are zero-extended, so the 33-bit difference covers the
  // full signed range of a 32-bit unsigned subtraction.
  function automatic logic [32:0] abs_diff33(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[32] ? (~d + 33'd1) : d;
  endfunction

endpackage

// File: rtl/powerup_slot_ctrl_bbox_overlap.sv
// Combinational sprite-box overlap test of one player against the spawn point.
//   px, py : player position (unsigned pixels)
//   hit    : 1 when |px-CX| <= W and |py-CY| <= H (boundary inclusive)
module powerup_slot_ctrl_bbox_overlap
  import powerup_slot_ctrl_pkg::*;
#(
  parameter int CX = 300,
  parameter int CY = 300,
  parameter int W  = DEF_SPRITE_W,
  parameter int H  = DEF_SPRITE_H
) (
  input  logic [31:0] px,
  input  logic [31:0] py,
  output logic        hit
);

  assign hit = (abs_diff33(px, 32'(CX)) <= 33'(W)) &&
               (abs_diff33(py, 32'(CY)) <= 33'(H));

endmodule

// File: rtl/powerup_slot_ctrl.sv
// Lifecycle sequencer for one map powerup: armed on the map, claimed by a
// player, held for HOLD_STAGES*TICK_DIV enabled cycles, off-map for
// RESPAWN_STAGES*TICK_DIV enabled cycles, then re-armed.
//   clock            : state changes on the falling edge, like the MMIO registers
//   reset            : asynchronous, active-high
//   enable           : 1 runs counters and allows claims; 0 freezes everything
//   clear            : level; force-expires a held powerup
//   player0/1_x/y    : player positions from MMIO
//   pu_x, pu_y       : spawn point while armed, OFFSCREEN otherwise
//   owner0, owner1   : current holder (never both)
//   stage            : stage index in HELD/RESPAWN, 0 in ARMED
//   grant_pulse      : one cycle when ownership is taken
//   expire_pulse     : one cycle when ownership is dropped
module powerup_slot_ctrl
  import powerup_slot_ctrl_pkg::*;
#(
  parameter int SPRITE_W       = DEF_SPRITE_W,
  parameter int SPRITE_H       = DEF_SPRITE_H,
  parameter int SPAWN_X        = 300,
  parameter int SPAWN_Y        = 300,
  parameter int TICK_DIV       = 100000000,
  parameter int HOLD_STAGES    = 7,
  parameter int RESPAWN_STAGES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] player0_x,
  input  logic [31:0] player0_y,
  input  logic [31:0] player1_x,
  input  logic [31:0] player1_y,
  output logic [31:0] pu_x,
  output logic [31:0] pu_y,
  output logic        owner0,
  output logic        owner1,
  output logic [3:0]  stage,
  output logic        grant_pulse,
  output logic        expire_pulse
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0] HOLD_LAST    = 4'(HOLD_STAGES);
  localparam logic [3:0] RESPAWN_LAST = 4'(RESPAWN_STAGES);

  slot_state_t       state_reg, state_next;
  logic [TICK_W-1:0] tick_reg, tick_next;
  logic [3:0]        stage_reg, stage_next;
  logic              owner0_reg, owner0_next;
  logic              owner1_reg, owner1_next;
  logic              last_winner_reg, last_winner_next;
  logic              grant_reg, grant_next;
  logic              expire_reg, expire_next;
  logic [31:0]       pu_x_reg, pu_x_next;
  logic [31:0]       pu_y_reg, pu_y_next;

  logic hit0, hit1, tie, win1, tick_last;

  powerup_slot_ctrl_bbox_overlap #(
    .CX(SPAWN_X), .CY(SPAWN_Y), .W(SPRITE_W), .H(SPRITE_H)
  ) u_overlap0 (
    .px (player0_x),
    .py (player0_y),
    .hit(hit0)
  );

  powerup_slot_ctrl_bbox_overlap #(
    .CX(SPAWN_X), .CY(SPAWN_Y), .W(SPRITE_W), .H(SPRITE_H)
  ) u_overlap1 (
    .px (player1_x),
    .py (player1_y),
    .hit(hit1)
  );

  // last_winner holds the player index of the previous tie winner; the
  // other player takes the next tie. A sole hitter does not move it.
  assign tie       = hit0 & hit1;
  assign win1      = tie ? ~last_winner_reg : hit1;
  assign tick_last = (tick_reg == TICK_LAST);

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ARMED;
      tick_reg        <= '0;
      stage_reg       <= 4'd0;
      owner0_reg      <= 1'b0;
      owner1_reg      <= 1'b0;
      last_winner_reg <= 1'b1;
      grant_reg       <= 1'b0;
      expire_reg      <= 1'b0;
      pu_x_reg        <= 32'(SPAWN_X);
      pu_y_reg        <= 32'(SPAWN_Y);
    end else begin
      state_reg       <= state_next;
      tick_reg        <= tick_next;
      stage_reg       <= stage_next;
      owner0_reg      <= owner0_next;
      owner1_reg      <= owner1_next;
      last_winner_reg <= last_winner_next;
      grant_reg       <= grant_next;
      expire_reg      <= expire_next;
      pu_x_reg        <= pu_x_next;
      pu_y_reg        <= pu_y_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    tick_next        = tick_reg;
    stage_next       = stage_reg;
    owner0_next      = owner0_reg;
    owner1_next      = owner1_reg;
    last_winner_next = last_winner_reg;
    grant_next       = 1'b0;
    expire_next      = 1'b0;
    pu_x_next        = pu_x_reg;
    pu_y_next        = pu_y_reg;

    if (enable) begin
      unique case (state_reg)
        ARMED: begin
          if (hit0 | hit1) begin
            state_next  = HELD;
            owner0_next = ~win1;
            owner1_next = win1;
            if (tie) last_winner_next = win1;
            pu_x_next   = OFFSCREEN;
            pu_y_next   = OFFSCREEN;
            grant_next  = 1'b1;
            tick_next   = '0;
            stage_next  = 4'd1;
          end
        end
        HELD: begin
          // clear wins over a natural expiry landing on the same cycle;
          // both take the same exit path.
          if (clear || (tick_last && stage_reg == HOLD_LAST)) begin
            state_next  = RESPAWN;
            owner0_next = 1'b0;
            owner1_next = 1'b0;
            expire_next = 1'b1;
            tick_next   = '0;
            stage_next  = 4'd1;
          end else if (tick_last) begin
            tick_next  = '0;
            stage_next = stage_reg + 4'd1;
          end else begin
            tick_next = tick_reg + TICK_W'(1);
          end
        end
        RESPAWN: begin
          // Claims are only evaluated in ARMED, so a re-arm edge can never
          // also grant; the earliest claim is the following edge.
          if (tick_last && stage_reg == RESPAWN_LAST) begin
            state_next = ARMED;
            pu_x_next  = 32'(SPAWN_X);
            pu_y_next  = 32'(SPAWN_Y);
            tick_next  = '0;
            stage_next = 4'd0;
          end else if (tick_last) begin
            tick_next  = '0;
            stage_next = stage_reg + 4'd1;
          end else begin
            tick_next = tick_reg + TICK_W'(1);
          end
        end
        default: begin
          // Unused encoding: fall back to a clean armed slot.
          state_next  = ARMED;
          owner0_next = 1'b0;
          owner1_next = 1'b0;
          pu_x_next   = 32'(SPAWN_X);
          pu_y_next   = 32'(SPAWN_Y);
          tick_next   = '0;
          stage_next  = 4'd0;
        end
      endcase
    end
  end

  assign pu_x         = pu_x_reg;
  assign pu_y         = pu_y_reg;
  assign owner0       = owner0_reg;
  assign owner1       = owner1_reg;
  assign stage        = stage_reg;
  assign grant_pulse  = grant_reg;
  assign expire_pulse = expire_reg;

endmodule
